// File: rtl/imem_arb_if.sv
// Bus bundle between imem_arb, the IFU, the program loader and the memory wrapper.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface imem_arb_if;
    // IFU line-read port
    logic         ifu_arb_req;
    logic [7:0]   ifu_arb_addr;
    logic         arb_ifu_gnt;
    logic         arb_ifu_rvld;
    logic [127:0] arb_ifu_rdata;

    // Loader word port
    logic         ldr_arb_vld;
    logic [11:0]  ldr_arb_addr;
    logic [31:0]  ldr_arb_data;
    logic         ldr_arb_last;
    logic         arb_ldr_rdy;
    logic         arb_ldr_idle;

    // Single-port memory
    logic         arb_mem_ce;
    logic         arb_mem_we;
    logic [7:0]   arb_mem_addr;
    logic [127:0] arb_mem_din;
    logic [127:0] mem_arb_dout;

    modport slave (
        input  ifu_arb_req,
        input  ifu_arb_addr,
        output arb_ifu_gnt,
        output arb_ifu_rvld,
        output arb_ifu_rdata,
        input  ldr_arb_vld,
        input  ldr_arb_addr,
        input  ldr_arb_data,
        input  ldr_arb_last,
        output arb_ldr_rdy,
        output arb_ldr_idle,
        output arb_mem_ce,
        output arb_mem_we,
        output arb_mem_addr,
        output arb_mem_din,
        input  mem_arb_dout
    );

    modport master (
        output ifu_arb_req,
        output ifu_arb_addr,
        input  arb_ifu_gnt,
        input  arb_ifu_rvld,
        input  arb_ifu_rdata,
        output ldr_arb_vld,
        output ldr_arb_addr,
        output ldr_arb_data,
        output ldr_arb_last,
        input  arb_ldr_rdy,
        input  arb_ldr_idle,
        input  arb_mem_ce,
        input  arb_mem_we,
        input  arb_mem_addr,
        input  arb_mem_din,
        output mem_arb_dout
    );
endinterface

// File: rtl/imem_arb.sv
// imem_arb: shares the single-port 256x128 instruction memory between IFU line reads and a
// loader write-combine buffer. Define IMEM_ARB_PERF_EN to add the arb_perf_stall counter output.
module imem_arb #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    imem_arb_if.slave   bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0] arb_perf_stall
`endif
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFill    = 3'd1;
    localparam logic [2:0] StCmtFull = 3'd2;
    localparam logic [2:0] StRmwRd   = 3'd3;
    localparam logic [2:0] StRmwWr   = 3'd4;

    localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

    logic [2:0]      state_q, state_d;
    logic [7:0]      line_addr_q, line_addr_d;
    logic [127:0]    line_data_q, line_data_d;
    logic [3:0]      mask_q, mask_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            rvld_q;

    logic            same_line;
    logic            ldr_rdy;
    logic            ldr_acc;
    logic            commit_pend;
    logic            ifu_gnt;
    logic            cmt_gnt;
    logic [1:0]      word_idx;
    logic [3:0]      word_bit;
    logic [3:0]      mask_acc;
    logic [127:0]    rmw_line;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^bus.ldr_arb_addr[1:0];

    assign word_idx  = bus.ldr_arb_addr[3:2];
    assign word_bit  = 4'b0001 << word_idx;
    assign same_line = (bus.ldr_arb_addr[11:4] == line_addr_q);

    assign ldr_rdy = !rst && ((state_q == StIdle) || ((state_q == StFill) && same_line));
    assign ldr_acc = bus.ldr_arb_vld && ldr_rdy;

    // IFU keeps priority over a pending commit only until it has won STARVE_LIM times in a row.
    assign commit_pend = (state_q == StCmtFull) || (state_q == StRmwRd);
    assign ifu_gnt     = !rst && bus.ifu_arb_req && (state_q != StRmwWr) &&
                         (!commit_pend || (starve_cnt_q < CntW'(STARVE_LIM)));
    assign cmt_gnt     = !rst && commit_pend && !ifu_gnt;

    assign mask_acc = ((state_q == StIdle) ? 4'b0000 : mask_q) | word_bit;

    always_comb begin
        rmw_line = '0;
        for (int i = 0; i < 4; i++) begin
            rmw_line[32*i +: 32] = mask_q[i] ? line_data_q[32*i +: 32]
                                             : bus.mem_arb_dout[32*i +: 32];
        end
    end

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        mask_d       = mask_q;
        starve_cnt_d = starve_cnt_q;

        if (ldr_acc) begin
            if (state_q == StIdle) begin
                line_addr_d = bus.ldr_arb_addr[11:4];
            end
            line_data_d[{word_idx, 5'b00000} +: 32] = bus.ldr_arb_data;
            mask_d = mask_acc;
            if (mask_acc == 4'hF) begin
                state_d = StCmtFull;
            end else if (bus.ldr_arb_last) begin
                state_d = StRmwRd;
            end else begin
                state_d = StFill;
            end
        end else begin
            case (state_q)
                StIdle: ;
                // A valid word refused in FILL belongs to another line: flush the partial one.
                StFill: begin
                    if (bus.ldr_arb_vld) begin
                        state_d = StRmwRd;
                    end
                end
                StCmtFull: begin
                    if (cmt_gnt) begin
                        state_d = StIdle;
                        mask_d  = '0;
                    end
                end
                StRmwRd: begin
                    if (cmt_gnt) begin
                        state_d = StRmwWr;
                    end
                end
                StRmwWr: begin
                    state_d = StIdle;
                    mask_d  = '0;
                end
                default: begin
                    state_d = StIdle;
                    mask_d  = '0;
                end
            endcase
        end

        if (cmt_gnt) begin
            starve_cnt_d = '0;
        end else if (commit_pend && ifu_gnt) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            starve_cnt_q <= '0;
            rvld_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            starve_cnt_q <= starve_cnt_d;
            rvld_q       <= ifu_gnt;
        end
    end

    // Buffer contents are qualified by mask_q, so they need no reset.
    always_ff @(posedge clk) begin
        line_addr_q <= line_addr_d;
        line_data_q <= line_data_d;
    end

    assign bus.arb_ifu_gnt   = ifu_gnt;
    assign bus.arb_ifu_rvld  = rvld_q;
    assign bus.arb_ifu_rdata = bus.mem_arb_dout;
    assign bus.arb_ldr_rdy   = ldr_rdy;
    assign bus.arb_ldr_idle  = (state_q == StIdle) && (mask_q == 4'b0000);

    assign bus.arb_mem_ce   = !rst && (ifu_gnt || cmt_gnt || (state_q == StRmwWr));
    assign bus.arb_mem_we   = !rst && ((cmt_gnt && (state_q == StCmtFull)) ||
                                       (state_q == StRmwWr));
    assign bus.arb_mem_addr = ifu_gnt ? bus.ifu_arb_addr : line_addr_q;
    assign bus.arb_mem_din  = (state_q == StRmwWr) ? rmw_line : line_data_q;

`ifdef IMEM_ARB_PERF_EN
    logic [15:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
        end else if (bus.ifu_arb_req && !ifu_gnt && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign arb_perf_stall = perf_stall_q;
`endif

    a_gnt_is_read: assert property (@(posedge clk) disable iff (rst)
        bus.arb_ifu_gnt |-> (bus.arb_mem_ce && !bus.arb_mem_we));
    a_starve_bound: assert property (@(posedge clk) disable iff (rst)
        starve_cnt_q <= CntW'(STARVE_LIM));
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        state_q <= StRmwWr);

endmodule

// File: tb/tb_imem_arb.sv
// Self-checking bench for imem_arb: directed table and sequences, then a randomized loader/IFU mix
// checked against a word-level image of what memory must hold once the loader drains.
module tb_imem_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_arb_if bus();

`ifdef IMEM_ARB_PERF_EN
    logic [15:0] perf;
    imem_arb #(.STARVE_LIM(4)) dut (.clk(clk), .rst(rst), .bus(bus), .arb_perf_stall(perf));
`else
    imem_arb #(.STARVE_LIM(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Memory wrapper stand-in with a preload port and a write log.
    logic [127:0] mem [256];
    logic         pl_en = 1'b0;
    logic [7:0]   pl_addr = '0;
    logic [127:0] pl_data = '0;
    int           cyc = 0;
    int           wcyc_q [$];
    logic [7:0]   waddr_q [$];
    logic [127:0] wdata_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.arb_mem_ce) begin
            if (bus.arb_mem_we) begin
                mem[bus.arb_mem_addr] <= bus.arb_mem_din;
                wcyc_q.push_back(cyc);
                waddr_q.push_back(bus.arb_mem_addr);
                wdata_q.push_back(bus.arb_mem_din);
            end else begin
                bus.mem_arb_dout <= mem[bus.arb_mem_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] ln, input logic [127:0] d);
        pl_en = 1'b1;
        pl_addr = ln;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Present one word; acc_c is the cycle number of the accepting edge.
    task automatic send(input logic [11:0] a, input logic [31:0] d, input logic l,
                        output int acc_c, output int waits);
        bit ok;
        ok = 1'b0;
        acc_c = 0;
        waits = 0;
        bus.ldr_arb_vld  = 1'b1;
        bus.ldr_arb_addr = a;
        bus.ldr_arb_data = d;
        bus.ldr_arb_last = l;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.arb_ldr_rdy) begin
                ok = 1'b1;
                acc_c = cyc;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        bus.ldr_arb_vld  = 1'b0;
        bus.ldr_arb_last = 1'b0;
        chki("send_accepted", int'(ok), 1);
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            @(negedge clk);
            done = bus.arb_ldr_idle;
        end
        chki("idle_reached", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [7:0] ea,
                          input logic [127:0] ed, input int ec);
        if (idx < wcyc_q.size()) begin
            chk({name, "_addr"}, 128'(waddr_q[idx]), 128'(ea));
            chk({name, "_data"}, wdata_q[idx], ed);
            chki({name, "_cycle"}, wcyc_q[idx], ec);
        end else begin
            chki({name, "_present"}, wcyc_q.size(), idx + 1);
        end
    endtask

    typedef struct {
        logic [11:0]  addr;
        logic [31:0]  data;
        logic [31:0]  pre;
        logic [7:0]   line;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [4];

    int acc, acc2, waits, base;
    logic [5:0] gbits, rbits;

    // Random-phase state
    logic [31:0]  ref_w [8][4];
    logic [127:0] pre_line, exp_line, exp_rd;
    logic [2:0]   r_ln;
    logic [1:0]   r_w;
    bit           pend, exp_rvld;
    int           left, cycles, stall;

    initial begin
        vt[0] = '{12'h054, 32'h0000_0007, 32'hAAAA_AAAA, 8'h05,
                  128'hAAAAAAAA_AAAAAAAA_00000007_AAAAAAAA};
        vt[1] = '{12'h0FC, 32'hDEAD_BEEF, 32'h1111_1111, 8'h0F,
                  128'hDEADBEEF_11111111_11111111_11111111};
        vt[2] = '{12'hFF0, 32'h1234_5678, 32'h5555_5555, 8'hFF,
                  128'h55555555_55555555_55555555_12345678};
        vt[3] = '{12'h3AB, 32'hCAFE_F00D, 32'h0000_0000, 8'h3A,
                  128'h00000000_CAFEF00D_00000000_00000000};

        rst = 1'b1;
        bus.ifu_arb_req  = 1'b1;
        bus.ifu_arb_addr = 8'h00;
        bus.ldr_arb_vld  = 1'b0;
        bus.ldr_arb_addr = '0;
        bus.ldr_arb_data = '0;
        bus.ldr_arb_last = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ce_forced", 128'(bus.arb_mem_ce), 128'(0));
        @(posedge clk);
        #1;
        bus.ifu_arb_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 128'(bus.arb_ifu_gnt), 128'(0));
        chk("rst_rdy", 128'(bus.arb_ldr_rdy), 128'(1));
        chk("rst_idle", 128'(bus.arb_ldr_idle), 128'(1));
        chk("rst_rvld", 128'(bus.arb_ifu_rvld), 128'(0));
        @(posedge clk);
        #1;

        // Single-word flushes by read-modify-write.
        for (int i = 0; i < 4; i++) begin
            preload(vt[i].line, {4{vt[i].pre}});
            base = wcyc_q.size();
            send(vt[i].addr, vt[i].data, 1'b1, acc, waits);
            wait_idle(10);
            chki($sformatf("tbl%0d_writes", i), wcyc_q.size(), base + 1);
            chk_wr($sformatf("tbl%0d", i), base, vt[i].line, vt[i].exp, acc + 2);
        end

        // Four words fill a line; one plain write the cycle after the fourth.
        preload(8'h00, {4{32'hFFFF_FFFF}});
        base = wcyc_q.size();
        for (int i = 0; i < 4; i++) begin
            send(12'(4 * i), 32'(i + 1), 1'b0, acc, waits);
            chki($sformatf("full_wait%0d", i), waits, 0);
        end
        wait_idle(10);
        chki("full_writes", wcyc_q.size(), base + 1);
        chk_wr("full", base, 8'h00, 128'h00000004_00000003_00000002_00000001, acc + 1);

        // A word for another line stalls until the partial line is flushed.
        preload(8'h01, 128'h0);
        preload(8'h02, 128'h0);
        base = wcyc_q.size();
        send(12'h010, 32'h0000_000A, 1'b0, acc, waits);
        send(12'h020, 32'h0000_000B, 1'b1, acc2, waits);
        chki("xline_waits", waits, 3);
        chki("xline_accept_cycle", acc2, acc + 4);
        chk_wr("xline_first", base, 8'h01, 128'h0000000A, acc + 3);
        wait_idle(10);
        chk_wr("xline_second", base + 1, 8'h02, 128'h0000000B, acc2 + 2);

        // Pending full line under continuous IFU traffic: four grants, then the commit.
        base = wcyc_q.size();
        bus.ifu_arb_req  = 1'b1;
        bus.ifu_arb_addr = 8'h10;
        for (int i = 0; i < 4; i++) begin
            send(12'h040 + 12'(4 * i), 32'h41 + 32'(i), 1'b0, acc, waits);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            gbits[k] = bus.arb_ifu_gnt;
            rbits[k] = bus.arb_ifu_rvld;
        end
        bus.ifu_arb_req = 1'b0;
        @(posedge clk);
        #1;
        chk("starve_gnt_pattern", 128'(gbits), 128'(6'b101111));
        chk("starve_rvld_pattern", 128'(rbits), 128'(6'b011111));
        chk_wr("starve", base, 8'h04, 128'h00000044_00000043_00000042_00000041, acc + 5);

        // Plain IFU read: grant now, data one cycle later.
        preload(8'h03, 128'h0123456789ABCDEF_FEDCBA9876543210);
        tick();
        bus.ifu_arb_req  = 1'b1;
        bus.ifu_arb_addr = 8'h03;
        @(negedge clk);
        chk("rd_gnt", 128'(bus.arb_ifu_gnt), 128'(1));
        chk("rd_ce_we", 128'({bus.arb_mem_ce, bus.arb_mem_we}), 128'(2'b10));
        chk("rd_addr", 128'(bus.arb_mem_addr), 128'(8'h03));
        @(posedge clk);
        #1;
        bus.ifu_arb_req = 1'b0;
        @(negedge clk);
        chk("rd_rvld", 128'(bus.arb_ifu_rvld), 128'(1));
        chk("rd_data", bus.arb_ifu_rdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
        @(negedge clk);
        chk("rd_rvld_drop", 128'(bus.arb_ifu_rvld), 128'(0));
        @(posedge clk);
        #1;

        // Reset while the read half of a read-modify-write is pending.
        preload(8'h09, {4{32'h9999_9999}});
        base = wcyc_q.size();
        send(12'h080, 32'hBAD0_BAD0, 1'b1, acc, waits);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ce", 128'(bus.arb_mem_ce), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chki("rstmid_no_write", wcyc_q.size(), base);
        chk("rstmid_idle", 128'(bus.arb_ldr_idle), 128'(1));
        chk("rstmid_rdy", 128'(bus.arb_ldr_rdy), 128'(1));
`ifdef IMEM_ARB_PERF_EN
        chk("rstmid_perf", 128'(perf), 128'(0));
`endif
        @(posedge clk);
        #1;
        send(12'h094, 32'h600D_600D, 1'b1, acc, waits);
        wait_idle(10);
        chk_wr("rstmid_after", base, 8'h09, 128'h99999999_99999999_600D600D_99999999, acc + 2);

        // Randomized mix over lines 0..7 with random IFU traffic.
        for (int ln = 0; ln < 8; ln++) begin
            pre_line = {$urandom, $urandom, $urandom, $urandom};
            preload(8'(ln), pre_line);
            for (int w = 0; w < 4; w++) begin
                ref_w[ln][w] = pre_line[32*w +: 32];
            end
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        stall = 0;
        exp_rvld = 1'b0;
        exp_rd = '0;
        pend = 1'b0;
        left = 200;
        cycles = 0;
        r_ln = '0;
        r_w = '0;
        while ((left > 0 || pend) && cycles < 4000) begin
            cycles++;
            bus.ifu_arb_req  = ($urandom_range(0, 3) != 0);
            bus.ifu_arb_addr = 8'($urandom_range(0, 15));
            if (!pend) begin
                bus.ldr_arb_vld  = 1'b0;
                bus.ldr_arb_last = 1'b0;
                if (left > 0 && $urandom_range(0, 3) != 0) begin
                    r_ln = 3'($urandom_range(0, 7));
                    r_w  = 2'($urandom_range(0, 3));
                    bus.ldr_arb_addr = {5'b00000, r_ln, r_w, 2'($urandom_range(0, 3))};
                    bus.ldr_arb_data = $urandom;
                    bus.ldr_arb_last = (left == 1) || ($urandom_range(0, 7) == 0);
                    bus.ldr_arb_vld  = 1'b1;
                    pend = 1'b1;
                    left--;
                end
            end
            @(negedge clk);
            if (exp_rvld) begin
                chk("rand_rvld", 128'(bus.arb_ifu_rvld), 128'(1));
                chk("rand_rdata", bus.arb_ifu_rdata, exp_rd);
            end else begin
                chk("rand_rvld_idle", 128'(bus.arb_ifu_rvld), 128'(0));
            end
            if (!bus.ifu_arb_req) begin
                chk("rand_gnt_noreq", 128'(bus.arb_ifu_gnt), 128'(0));
            end else if (bus.arb_ldr_idle) begin
                chk("rand_gnt_idle", 128'(bus.arb_ifu_gnt), 128'(1));
            end
            if (bus.arb_ifu_gnt) begin
                chk("rand_gnt_mem", 128'({bus.arb_mem_ce, bus.arb_mem_we, bus.arb_mem_addr}),
                    128'({2'b10, bus.ifu_arb_addr}));
                exp_rd = mem[bus.ifu_arb_addr];
            end
            if (bus.ifu_arb_req && !bus.arb_ifu_gnt && stall < 65535) begin
                stall++;
            end
            exp_rvld = bus.arb_ifu_gnt;
            if (pend && bus.arb_ldr_rdy) begin
                ref_w[r_ln][r_w] = bus.ldr_arb_data;
                pend = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chki("rand_words_left", left + int'(pend), 0);
        bus.ifu_arb_req  = 1'b0;
        bus.ldr_arb_vld  = 1'b0;
        bus.ldr_arb_last = 1'b0;
        wait_idle(60);
        for (int ln = 0; ln < 8; ln++) begin
            exp_line = {ref_w[ln][3], ref_w[ln][2], ref_w[ln][1], ref_w[ln][0]};
            chk($sformatf("rand_line%0d", ln), mem[ln], exp_line);
        end
`ifdef IMEM_ARB_PERF_EN
        chk("rand_perf", 128'(perf), 128'(stall));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
